// File: rtl/spi_pkg.sv
// spi_pkg: shared FSM state encoding and command-word layout for the SPI target
package spi_pkg;
  typedef enum logic [2:0] {IDLE, CMD, WDATA, FETCH, RDATA, DONE} state_t;
  function automatic int rw_pos(input int addr_bw);
    return addr_bw;
  endfunction
endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: multi-flop synchronizer with rise/fall detect on the synchronized level
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);
  logic [SYNC_STAGES-1:0] sync;
  logic prev;
  always_ff @(posedge clk) begin
    if (!rstn) begin
      sync <= {SYNC_STAGES{RST_VAL}};
      prev <= RST_VAL;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], d};
      prev <= sync[SYNC_STAGES-1];
    end
  end
  assign q    = sync[SYNC_STAGES-1];
  assign rise = q & ~prev;
  assign fall = ~q & prev;
endmodule

// File: rtl/spi_target.sv
// spi_target: 3-wire SPI responder turning command+data frames into register strobes
module spi_target
  import spi_pkg::*;
#(
  parameter int ADDR_BW     = 7,
  parameter int DATA_BW     = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               csn,
  input  logic               sclk,
  inout  wire                sdio,
  output logic [ADDR_BW-1:0] reg_addr,
  output logic [DATA_BW-1:0] reg_wdata,
  output logic               reg_we,
  output logic               reg_re,
  input  logic [DATA_BW-1:0] reg_rdata,
  output logic               busy,
  output logic               err
);
  localparam int CMD_W  = 1 + ADDR_BW;
  localparam int RX_W   = CMD_W > DATA_BW ? CMD_W : DATA_BW;
  localparam int CNT_W  = $clog2(RX_W) + 1;
  localparam int RW_POS = rw_pos(ADDR_BW);
  localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(ADDR_BW);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_BW - 1);
  localparam logic [CNT_W-1:0] DATA_N    = CNT_W'(DATA_BW);

  state_t                 state;
  logic [CNT_W-1:0]       cnt;
  logic [RX_W-1:0]        rx, rx_nx;
  logic [DATA_BW-1:0]     tx;
  logic                   oe, sdo;
  logic [SYNC_STAGES-1:0] sdio_sync;
  logic                   sdio_q, csn_q, csn_rise, csn_fall, sclk_q, sclk_rise, sclk_fall;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_csn (
    .clk(clk), .rstn(rstn), .d(csn), .q(csn_q), .rise(csn_rise), .fall(csn_fall)
  );
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
    .clk(clk), .rstn(rstn), .d(sclk), .q(sclk_q), .rise(sclk_rise), .fall(sclk_fall)
  );

  // data line shares the sclk/csn latency so a rising edge sees the matching bit
  always_ff @(posedge clk) begin
    if (!rstn) sdio_sync <= '0;
    else sdio_sync <= {sdio_sync[SYNC_STAGES-2:0], sdio};
  end
  assign sdio_q = sdio_sync[SYNC_STAGES-1];
  assign rx_nx  = {rx[RX_W-2:0], sdio_q};
  assign busy   = ~csn_q;
  assign sdio   = oe ? sdo : 1'bz;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= IDLE;
      cnt       <= '0;
      rx        <= '0;
      tx        <= '0;
      oe        <= 1'b0;
      sdo       <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_we    <= 1'b0;
      reg_re    <= 1'b0;
      err       <= 1'b0;
    end else begin
      reg_we <= 1'b0;
      reg_re <= 1'b0;
      err    <= 1'b0;
      if (csn_q) oe <= 1'b0;
      if (csn_rise) begin
        err   <= (state != IDLE) && (state != DONE);
        state <= IDLE;
      end else begin
        case (state)
          IDLE: if (csn_fall) begin
            state <= CMD;
            cnt   <= '0;
          end
          CMD: if (sclk_rise && sclk_q) begin
            rx  <= rx_nx;
            cnt <= cnt + 1'b1;
            if (cnt == CMD_LAST) begin
              cnt      <= '0;
              reg_addr <= rx_nx[ADDR_BW-1:0];
              reg_re   <= rx_nx[RW_POS];
              state    <= rx_nx[RW_POS] ? FETCH : WDATA;
            end
          end
          WDATA: if (sclk_rise) begin
            rx  <= rx_nx;
            cnt <= cnt + 1'b1;
            if (cnt == DATA_LAST) begin
              reg_wdata <= rx_nx[DATA_BW-1:0];
              reg_we    <= 1'b1;
              state     <= DONE;
            end
          end
          // first cycle carries reg_re, second captures the bank's answer
          FETCH: begin
            cnt <= cnt + 1'b1;
            if (cnt != '0) begin
              tx    <= reg_rdata;
              cnt   <= '0;
              state <= RDATA;
            end
          end
          RDATA: begin
            if (sclk_fall && cnt != DATA_N) begin
              oe  <= 1'b1;
              sdo <= tx[DATA_BW-1];
              tx  <= {tx[DATA_BW-2:0], 1'b0};
              cnt <= cnt + 1'b1;
            end else if (sclk_rise && cnt == DATA_N) begin
              state <= DONE;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_spi_target.sv
// tb_spi_target: randomized frames against a frame-level model of the SPI target
module tb_spi_target;
  logic       clk = 0, rstn = 0, csn = 1, sclk = 0, m_oe = 0, m_d = 0;
  wire        sdio;
  logic [6:0] reg_addr;
  logic [7:0] reg_wdata, m_rd;
  logic [7:0] reg_rdata = 0, rd_val = 0;
  logic       reg_we, reg_re, busy, err;
  int         n_checks = 0, n_errors = 0;
  int         we_n = 0, re_n = 0, err_n = 0, wide_n = 0, busy_starts = 0;
  logic       we_p = 0, re_p = 0, err_p = 0, busy_p = 0;
  logic [6:0] we_addr = 0, re_addr = 0;
  logic [7:0] we_data = 0;

  assign sdio = m_oe ? m_d : 1'bz;
  pullup (sdio);
  always #5 clk = ~clk;

  spi_target dut (
    .clk(clk), .rstn(rstn), .csn(csn), .sclk(sclk), .sdio(sdio),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we), .reg_re(reg_re),
    .reg_rdata(reg_rdata), .busy(busy), .err(err)
  );

  // register bank answers one cycle after reg_re, garbage otherwise
  always @(posedge clk) reg_rdata <= reg_re ? rd_val : 8'($urandom);

  always @(negedge clk) begin
    if (reg_we) begin
      we_n    <= we_n + 1;
      we_addr <= reg_addr;
      we_data <= reg_wdata;
    end
    if (reg_re) begin
      re_n    <= re_n + 1;
      re_addr <= reg_addr;
    end
    if (err) err_n <= err_n + 1;
    if ((reg_we && we_p) || (reg_re && re_p) || (err && err_p)) wide_n <= wide_n + 1;
    if (busy && !busy_p) busy_starts <= busy_starts + 1;
    we_p   <= reg_we;
    re_p   <= reg_re;
    err_p  <= err;
    busy_p <= busy;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic run_frame(input logic [7:0] cmd, input logic [7:0] dat, input int npulse,
                           input int abort_at, input int hp, input int gap, input logic [7:0] rdv);
    logic [15:0] bits;
    bits   = {cmd, dat};
    rd_val = rdv;
    m_rd   = '0;
    csn    = 0;
    wait_clk(hp);
    for (int i = 0; i < npulse; i++) begin
      if (i == abort_at) break;
      m_oe = (i < 8) || !cmd[7];
      m_d  = i < 16 ? bits[15-i] : 1'($urandom);
      wait_clk(hp);
      if (cmd[7] && i >= 8 && i < 16) m_rd[15-i] = sdio;
      sclk = 1;
      wait_clk(hp);
      sclk = 0;
    end
    m_oe = 0;
    wait_clk(hp);
    csn = 1;
    wait_clk(gap);
  endtask

  task automatic do_frame(input logic [7:0] cmd, input logic [7:0] dat, input int npulse,
                          input int abort_at, input int hp, input logic [7:0] rdv);
    int b_we, b_re, b_err, n;
    logic rw, full;
    b_we  = we_n;
    b_re  = re_n;
    b_err = err_n;
    run_frame(cmd, dat, npulse, abort_at, hp, 10, rdv);
    n    = npulse < abort_at ? npulse : abort_at;
    rw   = cmd[7];
    full = n >= 16;
    check("we_count", we_n - b_we, 32'(!rw && full));
    check("re_count", re_n - b_re, 32'(rw && n >= 8));
    check("err_count", err_n - b_err, 32'(!full));
    if (!rw && full) begin
      check("we_addr", we_addr, cmd[6:0]);
      check("we_data", we_data, dat);
    end
    if (rw && n >= 8) check("re_addr", re_addr, cmd[6:0]);
    if (rw && full) check("read_data", m_rd, rdv);
    check("busy_end", busy, 0);
    check("sdio_released", sdio, 1);
  endtask

  initial begin
    int b_we, b_re, b_err, b_busy;
    logic [7:0] c;
    wait_clk(3);
    check("rst_addr", reg_addr, 0);
    check("rst_wdata", reg_wdata, 0);
    check("rst_we", reg_we, 0);
    check("rst_re", reg_re, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_sdio", sdio, 1);
    rstn = 1;
    wait_clk(4);

    do_frame(8'h12, 8'hA5, 16, 99, 4, 8'h00);
    do_frame(8'h85, 8'h00, 16, 99, 4, 8'h3C);
    do_frame(8'h20, 8'h96, 16, 12, 4, 8'h00);
    do_frame(8'h20, 8'h5A, 16, 99, 4, 8'h00);
    do_frame(8'h33, 8'hC3, 20, 99, 4, 8'h00);

    c = 8'h85;
    rd_val = 8'h00;
    csn = 0;
    wait_clk(4);
    for (int i = 0; i < 11; i++) begin
      m_oe = i < 8;
      m_d  = i < 8 ? c[7-i] : 1'b0;
      wait_clk(4);
      sclk = 1;
      wait_clk(4);
      sclk = 0;
    end
    m_oe = 0;
    wait_clk(4);
    check("mid_read_drive", sdio, 0);
    rstn = 0;
    csn  = 1;
    wait_clk(1);
    check("mrst_sdio", sdio, 1);
    check("mrst_addr", reg_addr, 0);
    check("mrst_wdata", reg_wdata, 0);
    check("mrst_strobes", {reg_we, reg_re, err, busy}, 0);
    wait_clk(2);
    rstn = 1;
    wait_clk(4);
    do_frame(8'h01, 8'hFF, 16, 99, 4, 8'h00);

    b_we   = we_n;
    b_re   = re_n;
    b_err  = err_n;
    b_busy = busy_starts;
    run_frame(8'h7F, 8'h55, 16, 99, 4, 2, 8'h00);
    run_frame(8'hFF, 8'h00, 16, 99, 4, 10, 8'hC6);
    check("b2b_we", we_n - b_we, 1);
    check("b2b_re", re_n - b_re, 1);
    check("b2b_err", err_n - b_err, 0);
    check("b2b_we_addr", we_addr, 7'h7F);
    check("b2b_we_data", we_data, 8'h55);
    check("b2b_re_addr", re_addr, 7'h7F);
    check("b2b_rdata", m_rd, 8'hC6);
    check("b2b_busy_frames", busy_starts - b_busy, 2);

    for (int k = 0; k < 24; k++)
      do_frame(8'($urandom), 8'($urandom), $urandom_range(16, 20),
               $urandom_range(0, 3) == 0 ? int'($urandom_range(0, 15)) : 99,
               $urandom_range(4, 6), 8'($urandom));

    check("strobe_width", wide_n, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
